// File: rtl/multadd_seq.sv
// Sequencing controller for one multadd lane.
// Accepts add/sub/dot vector commands, streams operand pairs into the
// multadd unit and collects the accumulator output into a 2-entry result FIFO.
//
// Handshake rule used on every interface: a transfer happens on a rising
// clock edge exactly when valid and ready are both high in the preceding
// cycle; a valid side holds its payload stable until that transfer.
module multadd_seq #(
  parameter int vdw_p       = 32,
  parameter int len_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  // command interface
  input  logic                   cmd_v_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_op_i,
  input  logic [len_width_p-1:0] cmd_len_i,
  // operand pair stream
  input  logic                   opd_v_i,
  output logic                   opd_ready_o,
  input  logic [vdw_p-1:0]       opd_a_i,
  input  logic [vdw_p-1:0]       opd_b_i,
  // multadd lane control
  output logic [vdw_p-1:0]       ma_a_o,
  output logic [vdw_p-1:0]       ma_b_o,
  output logic                   ma_alu_op_o,
  output logic                   ma_use_fma_o,
  output logic                   ma_fma_first_o,
  input  logic [vdw_p-1:0]       ma_data_i,
  // result stream
  output logic                   res_v_o,
  input  logic                   res_ready_i,
  output logic [vdw_p-1:0]       res_data_o,
  // status
  output logic                   busy_o,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ELEM  = 2'd1,
    S_DOT   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   op_sub_q;     // element op is subtract
  logic [len_width_p-1:0] rem_q;        // operand pairs still to issue
  logic                   first_q;      // no dot issue yet: keep fma_first high
  logic                   inflight_q;   // element issued last cycle, push ma_data_i now
  logic                   zero_q;       // empty dot accepted last cycle, push 0 now
  logic [1:0]             cnt_q;        // results in flight or in FIFO (incl. dot reservation)
  logic [1:0]             cnt_d;

  // result FIFO storage
  logic [vdw_p-1:0]       mem_q [2];
  logic                   rd_ptr_q;
  logic                   wr_ptr_q;
  logic [1:0]             occ_q;

  logic                   pop;
  logic                   push;
  logic [vdw_p-1:0]       push_data;
  logic                   cnt_lt2;
  logic                   cmd_fire;
  logic                   issue;
  logic                   elem_issue;
  logic                   dot_accept;
  logic                   rem_last;

  assign res_v_o     = (occ_q != 2'd0);
  assign res_data_o  = mem_q[rd_ptr_q];
  assign pop         = res_v_o & res_ready_i;
  assign cnt_lt2     = (cnt_q != 2'd2);
  assign rem_last    = (rem_q == len_width_p'(1));

  // A dot command needs a FIFO slot reserved up front for its single result.
  assign cmd_ready_o = (state_q == S_IDLE) & (~cmd_op_i[1] | cnt_lt2);
  assign cmd_fire    = cmd_v_i & cmd_ready_o;
  assign dot_accept  = cmd_fire & cmd_op_i[1];

  // Element mode may issue into a full count if a pop frees a slot this cycle.
  assign opd_ready_o = ((state_q == S_ELEM) & (cnt_lt2 | pop)) | (state_q == S_DOT);
  assign issue       = opd_v_i & opd_ready_o;
  assign elem_issue  = issue & (state_q == S_ELEM);

  // Zero operands on non-issue cycles so the accumulator holds during dot gaps.
  assign ma_a_o         = issue ? opd_a_i : '0;
  assign ma_b_o         = issue ? opd_b_i : '0;
  assign ma_alu_op_o    = (state_q == S_ELEM) & op_sub_q;
  assign ma_use_fma_o   = (state_q == S_DOT);
  assign ma_fma_first_o = (state_q == S_DOT) & first_q;

  // One push source is active per cycle: element echo, empty dot, or dot drain.
  assign push      = inflight_q | zero_q | (state_q == S_DRAIN);
  assign push_data = zero_q ? '0 : ma_data_i;

  assign busy_o      = (state_q != S_IDLE) | inflight_q | zero_q;
  assign dbg_state_o = state_q;

  // Next value of the outstanding-result count.
  always_comb begin
    cnt_d = cnt_q;
    if (elem_issue || dot_accept) cnt_d = cnt_d + 2'd1;
    if (pop)                      cnt_d = cnt_d - 2'd1;
  end

  // Command sequencing FSM and its bookkeeping registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      op_sub_q   <= 1'b0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      inflight_q <= 1'b0;
      zero_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= elem_issue;
      zero_q     <= dot_accept & (cmd_len_i == '0);
      unique case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            op_sub_q <= cmd_op_i[0];
            rem_q    <= cmd_len_i;
            first_q  <= 1'b1;
            if (cmd_len_i != '0) begin
              state_q <= cmd_op_i[1] ? S_DOT : S_ELEM;
            end
          end
        end
        S_ELEM: begin
          if (issue) begin
            rem_q <= rem_q - len_width_p'(1);
            if (rem_last) state_q <= S_IDLE;
          end
        end
        S_DOT: begin
          if (issue) begin
            first_q <= 1'b0;
            rem_q   <= rem_q - len_width_p'(1);
            if (rem_last) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Two-entry result FIFO; push and pop in the same cycle are both honoured.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_multadd_seq.sv
// Bench for multadd_seq: a behavioural multadd lane model feeds ma_data_i,
// a scoreboard compares every popped result against an expected queue.
module tb_multadd_seq;

  localparam int W = 32;
  localparam int L = 8;

  // clock / reset
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic          cmd_v_i = 1'b0;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i = 2'd0;
  logic [L-1:0]  cmd_len_i = '0;
  logic          opd_v_i = 1'b0;
  logic          opd_ready_o;
  logic [W-1:0]  opd_a_i = '0;
  logic [W-1:0]  opd_b_i = '0;
  logic [W-1:0]  ma_a_o, ma_b_o;
  logic          ma_alu_op_o, ma_use_fma_o, ma_fma_first_o;
  logic [W-1:0]  ma_data_i;
  logic          res_v_o;
  logic          res_ready_i;
  logic [W-1:0]  res_data_o;
  logic          busy_o;
  logic [1:0]    dbg_state_o;

  logic man_ready = 1'b1;
  logic rnd_ready = 1'b1;
  logic rnd_en    = 1'b0;
  assign res_ready_i = rnd_en ? rnd_ready : man_ready;

  multadd_seq #(.vdw_p(W), .len_width_p(L)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i), .cmd_len_i(cmd_len_i),
    .opd_v_i(opd_v_i), .opd_ready_o(opd_ready_o), .opd_a_i(opd_a_i), .opd_b_i(opd_b_i),
    .ma_a_o(ma_a_o), .ma_b_o(ma_b_o), .ma_alu_op_o(ma_alu_op_o), .ma_use_fma_o(ma_use_fma_o),
    .ma_fma_first_o(ma_fma_first_o), .ma_data_i(ma_data_i),
    .res_v_o(res_v_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // Multadd lane model: un-enabled accumulator register behind mul/add.
  logic [W-1:0] acc;
  logic [W-1:0] prod;
  assign prod      = ma_a_o * ma_b_o;
  assign ma_data_i = acc;
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) acc <= '0;
    else if (ma_use_fma_o) acc <= (ma_fma_first_o ? '0 : acc) + prod;
    else acc <= ma_alu_op_o ? (ma_a_o - ma_b_o) : (ma_a_o + ma_b_o);
  end

  // random consumer backpressure when enabled
  always @(posedge clk_i) begin
    #1;
    rnd_ready = ($urandom_range(0, 1) == 1);
  end

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_a [16];
  logic [W-1:0] cur_b [16];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    else passes++;
  endtask

  // scoreboard: compare each pop against the expected queue; check hold rule
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_data = '0;
  always @(negedge clk_i) begin
    if (reset_i) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("res_hold_v", {31'd0, res_v_o}, 32'd1);
        check("res_hold_data", res_data_o, hold_data);
      end
      if (res_v_o && res_ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", res_data_o, 32'hxxxx_xxxx);
        end else begin
          check("sb_result", res_data_o, exp_q.pop_front());
        end
      end
      hold_pend = res_v_o && !res_ready_i;
      hold_data = res_data_o;
    end
  end

  // reference model: expected results of one command from plain arithmetic
  task automatic ref_push(input logic [1:0] op, input int len);
    logic [W-1:0] sum;
    logic [W-1:0] v;
    if (op[1]) begin
      sum = '0;
      for (int i = 0; i < len; i++) begin
        v = cur_a[i] * cur_b[i];
        sum = sum + v;
      end
      exp_q.push_back(sum);
    end else begin
      for (int i = 0; i < len; i++) begin
        v = op[0] ? (cur_a[i] - cur_b[i]) : (cur_a[i] + cur_b[i]);
        exp_q.push_back(v);
      end
    end
  endtask

  // driver: present a command until accepted
  task automatic send_cmd(input logic [1:0] op, input int len);
    int n;
    cmd_v_i = 1'b1; cmd_op_i = op; cmd_len_i = L'(len);
    n = 0;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 300) begin @(negedge clk_i); n++; end
    check("cmd_handshake", {31'd0, cmd_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    cmd_v_i = 1'b0;
  endtask

  // driver: present one operand pair after gap idle cycles, until consumed
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
    int n;
    opd_v_i = 1'b0;
    repeat (gap) begin @(posedge clk_i); #1; end
    opd_v_i = 1'b1; opd_a_i = a; opd_b_i = b;
    n = 0;
    @(negedge clk_i);
    while (!opd_ready_o && n < 300) begin @(negedge clk_i); n++; end
    check("opd_handshake", {31'd0, opd_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    opd_v_i = 1'b0;
  endtask

  task automatic drive_raw(input logic [1:0] op, input int len, input int gap);
    send_cmd(op, len);
    for (int i = 0; i < len; i++) send_pair(cur_a[i], cur_b[i], gap);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_i);
    while ((busy_o || res_v_o) && n < 1000) begin @(negedge clk_i); n++; end
    check("idle_reached", {30'd0, busy_o, res_v_o}, 32'd0);
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic [1:0]          op;
    int                  len;
    int                  gap;
    logic [3:0][W-1:0]   a;
    logic [3:0][W-1:0]   b;
    int                  n_exp;
    logic [3:0][W-1:0]   exp_r;
  } vec_t;

  vec_t tbl [7];

  initial begin
    // vector table; packed lists read element 3 first, element 0 last
    tbl[0] = '{op: 2'd0, len: 4, gap: 0,
               a: {32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd40, 32'd30, 32'd20, 32'd10},
               n_exp: 4, exp_r: {32'd44, 32'd33, 32'd22, 32'd11}};
    tbl[1] = '{op: 2'd1, len: 2, gap: 0,
               a: {32'd0, 32'd0, 32'd0, 32'd5}, b: {32'd0, 32'd0, 32'd1, 32'd7},
               n_exp: 2, exp_r: {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}};
    tbl[2] = '{op: 2'd2, len: 3, gap: 2,
               a: {32'd0, 32'd3, 32'd2, 32'd1}, b: {32'd0, 32'd6, 32'd5, 32'd4},
               n_exp: 1, exp_r: {32'd0, 32'd0, 32'd0, 32'd32}};
    tbl[3] = '{op: 2'd3, len: 0, gap: 0, a: '0, b: '0,
               n_exp: 1, exp_r: {32'd0, 32'd0, 32'd0, 32'd0}};
    tbl[4] = '{op: 2'd0, len: 0, gap: 0, a: '0, b: '0, n_exp: 0, exp_r: '0};
    tbl[5] = '{op: 2'd3, len: 2, gap: 1,
               a: {32'd0, 32'd0, 32'd3, 32'h8000_0000}, b: {32'd0, 32'd0, 32'd3, 32'd2},
               n_exp: 1, exp_r: {32'd0, 32'd0, 32'd0, 32'd9}};
    tbl[6] = '{op: 2'd1, len: 1, gap: 0,
               a: {32'd0, 32'd0, 32'd0, 32'd100}, b: {32'd0, 32'd0, 32'd0, 32'd58},
               n_exp: 1, exp_r: {32'd0, 32'd0, 32'd0, 32'd42}};

    // reset: outputs quiet while reset is held and after release
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_res_v", {31'd0, res_v_o}, 32'd0);
    check("rst_opd_ready", {31'd0, opd_ready_o}, 32'd0);
    check("rst_ma_a", ma_a_o, 32'd0);
    check("rst_ma_b", ma_b_o, 32'd0);
    check("rst_ma_ctl", {29'd0, ma_alu_op_o, ma_use_fma_o, ma_fma_first_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    check("post_rst_res_v", {31'd0, res_v_o}, 32'd0);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    check("post_rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);

    // table-driven vectors
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 4; i++) begin
        cur_a[i] = tbl[t].a[i];
        cur_b[i] = tbl[t].b[i];
      end
      for (int i = 0; i < tbl[t].n_exp; i++) exp_q.push_back(tbl[t].exp_r[i]);
      drive_raw(tbl[t].op, tbl[t].len, tbl[t].gap);
      wait_idle();
      check("tbl_all_results_seen", exp_q.size(), 32'd0);
    end

    // add len=4 back to back: ready never drops, results at issue+2
    exp_q.push_back(32'd11); exp_q.push_back(32'd22);
    exp_q.push_back(32'd33); exp_q.push_back(32'd44);
    send_cmd(2'd0, 4);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        opd_v_i = 1'b1; opd_a_i = W'(i + 1); opd_b_i = W'(10 * (i + 1));
      end else begin
        opd_v_i = 1'b0;
      end
      @(negedge clk_i);
      if (i < 4) check("stream_opd_ready", {31'd0, opd_ready_o}, 32'd1);
      check("stream_res_v_timing", {31'd0, res_v_o}, {31'd0, (i >= 2 && i <= 5)});
      @(posedge clk_i); #1;
    end
    opd_v_i = 1'b0;
    wait_idle();
    check("stream_all_seen", exp_q.size(), 32'd0);

    // add len=5 under backpressure: 2 buffered, 3rd pair held
    for (int i = 0; i < 5; i++) begin cur_a[i] = W'(i * 7 + 1); cur_b[i] = W'(i + 100); end
    ref_push(2'd0, 5);
    man_ready = 1'b0;
    send_cmd(2'd0, 5);
    send_pair(cur_a[0], cur_b[0], 0);
    send_pair(cur_a[1], cur_b[1], 0);
    opd_v_i = 1'b1; opd_a_i = cur_a[2]; opd_b_i = cur_b[2];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("bp_opd_ready_low", {31'd0, opd_ready_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check("bp_res_v", {31'd0, res_v_o}, 32'd1);
    check("bp_head", res_data_o, cur_a[0] + cur_b[0]);
    @(posedge clk_i); #1;
    man_ready = 1'b1;
    send_pair(cur_a[2], cur_b[2], 0);
    send_pair(cur_a[3], cur_b[3], 0);
    send_pair(cur_a[4], cur_b[4], 0);
    wait_idle();
    check("bp_all_seen", exp_q.size(), 32'd0);

    // elem len=0: no result, command port ready again next cycle
    send_cmd(2'd1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("len0_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      check("len0_no_result", {31'd0, res_v_o}, 32'd0);
      @(posedge clk_i); #1;
    end

    // reset in the middle of a dot product after two issues
    send_cmd(2'd2, 3);
    send_pair(32'd1, 32'd4, 0);
    send_pair(32'd2, 32'd5, 0);
    reset_i = 1'b1;
    #1;
    check("midrst_res_v", {31'd0, res_v_o}, 32'd0);
    check("midrst_opd_ready", {31'd0, opd_ready_o}, 32'd0);
    check("midrst_ma_ab", ma_a_o | ma_b_o, 32'd0);
    check("midrst_ma_ctl", {29'd0, ma_alu_op_o, ma_use_fma_o, ma_fma_first_o}, 32'd0);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    cur_a[0] = 32'd3; cur_b[0] = 32'd3;
    exp_q.push_back(32'd9);
    drive_raw(2'd2, 1, 0);
    wait_idle();
    check("midrst_clean_dot", exp_q.size(), 32'd0);

    // randomized commands against the reference model, random backpressure
    rnd_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      logic [1:0] op;
      int len, gap;
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 6);
      gap = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) begin
        cur_a[i] = (op[1] && $urandom_range(0, 1) == 1) ? W'($urandom_range(0, 255)) : $urandom;
        cur_b[i] = $urandom;
      end
      ref_push(op, len);
      drive_raw(op, len, gap);
    end
    rnd_en = 1'b0;
    wait_idle();
    check("rand_all_seen", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // watchdog: the bench must always end on its own
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
